// File: rtl/fifo_word_serializer_if.sv
// Bundle between the show-ahead FIFO read side, the serializer and the bit-serial link.
// master = serializer side, slave = FIFO/link side.
interface fifo_word_serializer_if #(
  parameter int unsigned WL     = 4,
  parameter int unsigned CNT_WL = 8
);
  logic              EN;
  logic              EMPTY;
  logic [WL-1:0]     head;
  logic              POP;
  logic              TX_VLD;
  logic              TX_RDY;
  logic              TX_BIT;
  logic              TX_LAST;
  logic              BUSY;
  logic [CNT_WL-1:0] WORD_CNT;

  modport master (
    input  EN, EMPTY, head, TX_RDY,
    output POP, TX_VLD, TX_BIT, TX_LAST, BUSY, WORD_CNT
  );

  modport slave (
    output EN, EMPTY, head, TX_RDY,
    input  POP, TX_VLD, TX_BIT, TX_LAST, BUSY, WORD_CNT
  );
endinterface

// File: rtl/fifo_word_serializer.sv
// Pops words from a show-ahead FIFO and shifts them out one bit per valid/ready beat.
// Refills on the last beat of a word so back-to-back words stream without a bubble.
module fifo_word_serializer #(
  parameter int unsigned WL        = 4,
  parameter int unsigned MSB_FIRST = 0,
  parameter int unsigned CNT_WL    = 8
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  fifo_word_serializer_if.master bus
);
  localparam int unsigned CW = $clog2(WL);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [WL-1:0]     shreg_q, shreg_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [CNT_WL-1:0] wcnt_q, wcnt_d;
  logic              pop_c;
  logic              beat_c;
  logic              last_c;
  logic              fetch_ok_c;

  assign fetch_ok_c = bus.EN & ~bus.EMPTY;
  assign last_c     = (state_q == SHIFT) && (cnt_q == CW'(WL - 1));
  assign beat_c     = (state_q == SHIFT) & bus.TX_RDY;

  // Next-state, datapath and pop strobe.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    wcnt_d  = wcnt_q;
    pop_c   = 1'b0;
    case (state_q)
      IDLE: begin
        if (fetch_ok_c) begin
          pop_c   = 1'b1;
          shreg_d = bus.head;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (beat_c) begin
          // Shifting on the final beat too leaves the register zeroed once idle.
          shreg_d = (MSB_FIRST != 0) ? {shreg_q[WL-2:0], 1'b0}
                                     : {1'b0, shreg_q[WL-1:1]};
          cnt_d   = cnt_q + CW'(1);
          if (last_c) begin
            wcnt_d = wcnt_q + CNT_WL'(1);
            if (fetch_ok_c) begin
              pop_c   = 1'b1;
              shreg_d = bus.head;
              cnt_d   = '0;
            end else begin
              state_d = IDLE;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      wcnt_q  <= wcnt_d;
    end
  end

  assign bus.POP      = pop_c;
  assign bus.TX_VLD   = (state_q == SHIFT);
  assign bus.BUSY     = (state_q == SHIFT);
  assign bus.TX_BIT   = (MSB_FIRST != 0) ? shreg_q[WL-1] : shreg_q[0];
  assign bus.TX_LAST  = last_c;
  assign bus.WORD_CNT = wcnt_q;
endmodule

// File: tb/tb_fifo_word_serializer.sv
// Randomized bench for fifo_word_serializer against a word-level reference model.
module tb_fifo_word_serializer;
  localparam int unsigned WL     = 4;
  localparam int unsigned CNT_WL = 8;

  logic CLK = 1'b0;
  logic RST_N = 1'b0;
  always #5 CLK = ~CLK;

  fifo_word_serializer_if #(.WL(WL), .CNT_WL(CNT_WL)) b0 ();
  fifo_word_serializer_if #(.WL(WL), .CNT_WL(CNT_WL)) b1 ();

  fifo_word_serializer #(.WL(WL), .MSB_FIRST(0), .CNT_WL(CNT_WL)) u_lsb (
    .CLK(CLK), .RST_N(RST_N), .bus(b0)
  );
  fifo_word_serializer #(.WL(WL), .MSB_FIRST(1), .CNT_WL(CNT_WL)) u_msb (
    .CLK(CLK), .RST_N(RST_N), .bus(b1)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: FIFO contents, word in flight and bits still to send.
  logic [WL-1:0] fifo_q[$];
  logic [WL-1:0] cur;
  int            rem;
  int            m_cnt;
  int            pop_cnt;
  logic          obs_bits[$];

  // One clock: drive inputs, compare at negedge, advance model, return at posedge+1.
  task automatic cycle(input logic rdy);
    logic exp_vld, exp_last, exp_bit, exp_pop, beat;
    b0.TX_RDY = rdy;
    b0.EMPTY  = (fifo_q.size() == 0);
    b0.head   = (fifo_q.size() == 0) ? '0 : fifo_q[0];
    @(negedge CLK);
    exp_vld  = (rem > 0);
    exp_last = (rem == 1);
    exp_bit  = (rem > 0) ? cur[WL - rem] : 1'b0;
    beat     = exp_vld && rdy;
    exp_pop  = b0.EN && (fifo_q.size() > 0) && ((rem == 0) || (beat && rem == 1));
    n_cmp += 5;
    if (b0.POP !== exp_pop) begin
      n_err++; $display("FAIL pop t=%0t got %b exp %b", $time, b0.POP, exp_pop);
    end
    if (b0.TX_VLD !== exp_vld) begin
      n_err++; $display("FAIL tx_vld t=%0t got %b exp %b", $time, b0.TX_VLD, exp_vld);
    end
    if (b0.TX_LAST !== exp_last) begin
      n_err++; $display("FAIL tx_last t=%0t got %b exp %b", $time, b0.TX_LAST, exp_last);
    end
    if (b0.BUSY !== exp_vld) begin
      n_err++; $display("FAIL busy t=%0t got %b exp %b", $time, b0.BUSY, exp_vld);
    end
    if (b0.WORD_CNT !== CNT_WL'(m_cnt)) begin
      n_err++; $display("FAIL word_cnt t=%0t got %0d exp %0d", $time, b0.WORD_CNT, m_cnt);
    end
    if (exp_vld) begin
      n_cmp++;
      if (b0.TX_BIT !== exp_bit) begin
        n_err++; $display("FAIL tx_bit t=%0t got %b exp %b", $time, b0.TX_BIT, exp_bit);
      end
    end
    if (beat) begin
      obs_bits.push_back(b0.TX_BIT);
      rem--;
      if (rem == 0) m_cnt = (m_cnt + 1) % (1 << CNT_WL);
    end
    if (exp_pop) begin
      cur = fifo_q.pop_front();
      rem = WL;
      pop_cnt++;
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    #1;
    n_cmp++;
    if ({b0.POP, b0.TX_VLD, b0.TX_BIT, b0.TX_LAST, b0.BUSY} !== 5'b0 || b0.WORD_CNT !== '0) begin
      n_err++; $display("FAIL reset_outputs got %b/%0d exp 00000/0",
        {b0.POP, b0.TX_VLD, b0.TX_BIT, b0.TX_LAST, b0.BUSY}, b0.WORD_CNT);
    end
    @(negedge CLK);
    RST_N = 1'b1;
    @(posedge CLK);
    #1;
  endtask

  task automatic test_two_words();
    logic exp_seq [8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    obs_bits.delete();
    fifo_q.push_back(4'd3);
    fifo_q.push_back(4'd4);
    b0.EN = 1'b1;
    for (int i = 0; i < 12; i++) cycle(1'b1);
    n_cmp += 3;
    if (obs_bits.size() != 8) begin
      n_err++; $display("FAIL two_words_len got %0d exp 8", obs_bits.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        n_cmp++;
        if (obs_bits[i] !== exp_seq[i]) begin
          n_err++; $display("FAIL two_words_bit%0d got %b exp %b", i, obs_bits[i], exp_seq[i]);
        end
      end
    end
    if (b0.WORD_CNT !== CNT_WL'(2)) begin
      n_err++; $display("FAIL two_words_cnt got %0d exp 2", b0.WORD_CNT);
    end
    if (b0.TX_VLD !== 1'b0) begin
      n_err++; $display("FAIL two_words_idle got %b exp 0", b0.TX_VLD);
    end
  endtask

  task automatic test_backpressure();
    logic rdy_pat [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    int   p0;
    p0 = pop_cnt;
    obs_bits.delete();
    fifo_q.push_back(4'd7);
    cycle(1'b1);
    for (int i = 0; i < 7; i++) cycle(rdy_pat[i]);
    for (int i = 0; i < 4; i++) cycle(1'b1);
    n_cmp += 2;
    if (pop_cnt - p0 != 1 || obs_bits.size() != 4) begin
      n_err++; $display("FAIL backpressure_counts got pops=%0d beats=%0d exp 1/4",
        pop_cnt - p0, obs_bits.size());
    end
    if (b0.WORD_CNT !== CNT_WL'(3)) begin
      n_err++; $display("FAIL backpressure_cnt got %0d exp 3", b0.WORD_CNT);
    end
  endtask

  task automatic test_empty_idle();
    for (int i = 0; i < 10; i++) cycle(1'($urandom_range(0, 1)));
    n_cmp++;
    if (b0.BUSY !== 1'b0 || b0.WORD_CNT !== CNT_WL'(3)) begin
      n_err++; $display("FAIL empty_idle got busy=%b cnt=%0d exp 0/3", b0.BUSY, b0.WORD_CNT);
    end
  endtask

  task automatic test_enable_gate();
    int p0;
    p0 = pop_cnt;
    fifo_q.push_back(4'd6);
    fifo_q.push_back(4'd2);
    b0.EN = 1'b1;
    cycle(1'b1);
    b0.EN = 1'b0;
    for (int i = 0; i < 8; i++) cycle(1'b1);
    n_cmp++;
    if (pop_cnt - p0 != 1 || fifo_q.size() != 1 || b0.BUSY !== 1'b0) begin
      n_err++; $display("FAIL en_hold got pops=%0d busy=%b exp 1/0", pop_cnt - p0, b0.BUSY);
    end
    b0.EN = 1'b1;
    for (int i = 0; i < 7; i++) cycle(1'b1);
    n_cmp++;
    if (b0.WORD_CNT !== CNT_WL'(5)) begin
      n_err++; $display("FAIL en_resume_cnt got %0d exp 5", b0.WORD_CNT);
    end
  endtask

  task automatic test_async_reset();
    fifo_q.push_back(4'd5);
    b0.EN = 1'b1;
    cycle(1'b1);
    cycle(1'b1);
    cycle(1'b1);
    #2;
    RST_N = 1'b0;
    #1;
    n_cmp++;
    if ({b0.POP, b0.TX_VLD, b0.TX_BIT, b0.TX_LAST, b0.BUSY} !== 5'b0 || b0.WORD_CNT !== '0) begin
      n_err++; $display("FAIL async_reset got %b/%0d exp 00000/0",
        {b0.POP, b0.TX_VLD, b0.TX_BIT, b0.TX_LAST, b0.BUSY}, b0.WORD_CNT);
    end
    rem   = 0;
    m_cnt = 0;
    @(negedge CLK);
    RST_N = 1'b1;
    @(posedge CLK);
    #1;
    for (int i = 0; i < 5; i++) cycle(1'b1);
  endtask

  task automatic test_random();
    for (int i = 0; i < 1400; i++) begin
      if (fifo_q.size() < 8 && $urandom_range(0, 3) != 0) fifo_q.push_back(WL'($urandom));
      if ($urandom_range(0, 19) == 0) b0.EN = ~b0.EN;
      cycle(1'($urandom_range(0, 4) != 0));
    end
    b0.EN = 1'b1;
    for (int i = 0; i < 60; i++) cycle(1'b1);
    n_cmp++;
    if (fifo_q.size() != 0 || b0.BUSY !== 1'b0) begin
      n_err++; $display("FAIL random_drain got left=%0d busy=%b exp 0/0", fifo_q.size(), b0.BUSY);
    end
  endtask

  task automatic test_msb_first();
    logic [WL-1:0] w;
    int            nb;
    int            npop;
    w    = 4'd1;
    nb   = 0;
    npop = 0;
    b1.head   = w;
    b1.EMPTY  = 1'b0;
    b1.TX_RDY = 1'b1;
    b1.EN     = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge CLK);
      if (b1.TX_VLD === 1'b1) begin
        n_cmp += 2;
        if (nb >= WL || b1.TX_BIT !== w[WL - 1 - nb]) begin
          n_err++; $display("FAIL msb_bit%0d got %b", nb, b1.TX_BIT);
        end
        if (b1.TX_LAST !== (nb == WL - 1)) begin
          n_err++; $display("FAIL msb_last%0d got %b exp %b", nb, b1.TX_LAST, nb == WL - 1);
        end
        nb++;
      end
      if (b1.POP === 1'b1) npop++;
      @(posedge CLK);
      #1;
      if (npop > 0) b1.EMPTY = 1'b1;
    end
    n_cmp++;
    if (nb != WL || npop != 1 || b1.WORD_CNT !== CNT_WL'(1)) begin
      n_err++; $display("FAIL msb_counts got beats=%0d pops=%0d cnt=%0d exp 4/1/1",
        nb, npop, b1.WORD_CNT);
    end
  endtask

  initial begin
    b0.EN = 1'b0; b0.EMPTY = 1'b1; b0.head = '0; b0.TX_RDY = 1'b0;
    b1.EN = 1'b0; b1.EMPTY = 1'b1; b1.head = '0; b1.TX_RDY = 1'b0;
    rem = 0; m_cnt = 0; pop_cnt = 0; cur = '0;
    test_reset();
    test_two_words();
    test_backpressure();
    test_empty_idle();
    test_enable_gate();
    test_async_reset();
    test_random();
    test_msb_first();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
